poly_synth_engine: RTL and testbench



---
 rtl/poly_synth_engine.sv | 175 +++++++++++++++++
 tb/tb_poly_synth_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_synth_engine.sv
// poly_synth_engine: N-voice time-multiplexed synthesizer. Each frame walks
// the voices one per clock, accumulates the volume-scaled waveform samples
// and emits one saturated signed sample.
// Optional build macro POLY_SYNTH_NOISE_EN: mode 3 becomes LFSR noise instead
// of silence.
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | waiting for sample_tick
// ACCUM | processing voice idx, one voice per clock
// EMIT  | saturate accumulator onto out, pulse out_valid
module poly_synth_engine #(
    parameter int N_VOICES = 8,
    parameter int PHASE_W  = 32,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic [N_VOICES-1:0]          gate,
    input  logic [2*N_VOICES-1:0]        mode,
    input  logic [PHASE_W*N_VOICES-1:0]  phase_inc,
    input  logic [VOL_W*N_VOICES-1:0]    volume,
    output logic signed [SAMPLE_W-1:0]   out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(N_VOICES) + 1;
    // Wide enough for signed wave times zero-extended volume without overflow.
    localparam int PROD_W = ACC_W + VOL_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    localparam logic signed [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SQ_NEG = -SQ_POS;
    localparam logic [SAMPLE_W-1:0] MSB_ONLY = {1'b1, {(SAMPLE_W-1){1'b0}}};

    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic [PHASE_W-1:0]       phase [N_VOICES];

`ifdef POLY_SYNTH_NOISE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
`endif

    logic                        cur_gate;
    logic [1:0]                  cur_mode;
    logic [PHASE_W-1:0]          cur_inc;
    logic [VOL_W-1:0]            cur_vol;
    logic [PHASE_W-1:0]          cur_phase;
    logic [SAMPLE_W-1:0]         p;
    logic [SAMPLE_W-2:0]         tri_t;
    logic signed [SAMPLE_W-1:0]  wave;
    logic signed [PROD_W-1:0]    wave_ext;
    logic signed [PROD_W-1:0]    vol_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     scaled;
    logic signed [SAMPLE_W-1:0]  sat_val;

    // Select the current voice's live config and form its scaled contribution.
    always_comb begin
        cur_gate  = gate[idx];
        cur_mode  = mode[int'(idx)*2 +: 2];
        cur_inc   = phase_inc[int'(idx)*PHASE_W +: PHASE_W];
        cur_vol   = volume[int'(idx)*VOL_W +: VOL_W];
        cur_phase = phase[idx];
        p         = cur_phase[PHASE_W-1 -: SAMPLE_W];
        tri_t     = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        wave      = '0;
        case (cur_mode)
            2'd0:    wave = p[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
            2'd1:    wave = p ^ MSB_ONLY;
            2'd2:    wave = {tri_t, 1'b0} ^ MSB_ONLY;
`ifdef POLY_SYNTH_NOISE_EN
            default: wave = SAMPLE_W'($signed(lfsr));
`else
            default: wave = '0;
`endif
        endcase
        wave_ext = PROD_W'(wave);
        vol_ext  = {{(PROD_W-VOL_W){1'b0}}, cur_vol};
        prod     = wave_ext * vol_ext;
        scaled   = cur_gate ? ACC_W'(prod >>> VOL_W) : '0;
    end

    // Clamp the frame accumulator into the signed output range.
    always_comb begin
        if (acc > SAT_HI)
            sat_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (acc < SAT_LO)
            sat_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            sat_val = acc[SAMPLE_W-1:0];
    end

`ifdef POLY_SYNTH_NOISE_EN
    // Galois step of the shared noise LFSR.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    // Frame sequencer: voice walk, phase update, accumulation and emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_VOICES; i++)
                phase[i] <= '0;
`ifdef POLY_SYNTH_NOISE_EN
            lfsr      <= 16'hACE1;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= ACCUM;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (sample_tick)
                        overrun <= 1'b1;
                    acc <= acc + scaled;
                    // A gated-off voice is held at phase 0 so it restarts cleanly.
                    phase[idx] <= cur_gate ? (cur_phase + cur_inc) : '0;
`ifdef POLY_SYNTH_NOISE_EN
                    if (cur_gate && (cur_mode == 2'd3))
                        lfsr <= lfsr_next;
`endif
                    if (idx == LAST_IDX) begin
                        state <= EMIT;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (sample_tick)
                        overrun <= 1'b1;
                    out       <= sat_val;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_synth_engine.sv
// Directed bench for poly_synth_engine at default parameters (8 voices,
// 32-bit phase, 16-bit samples, 8-bit volume).
module tb_poly_synth_engine;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_tick = 1'b0;
    logic [7:0]   gate = '0;
    logic [15:0]  mode = '0;
    logic [255:0] phase_inc = '0;
    logic [63:0]  volume = '0;
    logic [15:0]  out_s;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int failures = 0;
    int lat;
    int busy_n;
    int pulses;
    logic [15:0] res;

    poly_synth_engine dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .gate        (gate),
        .mode        (mode),
        .phase_inc   (phase_inc),
        .volume      (volume),
        .out         (out_s),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_voices();
        gate = '0;
        mode = '0;
        phase_inc = '0;
        volume = '0;
    endtask

    task automatic set_voice(input int i, input logic g, input logic [1:0] m,
                             input logic [31:0] inc, input logic [7:0] vol);
        gate[i] = g;
        mode[i*2 +: 2] = m;
        phase_inc[i*32 +: 32] = inc;
        volume[i*8 +: 8] = vol;
    endtask

    // Issue one tick, then count edges until out_valid (bounded at 20).
    task automatic run_frame(output int lat_o, output int busy_o, output logic [15:0] res_o);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        busy_o = busy ? 1 : 0;
        lat_o = 0;
        res_o = '0;
        while (lat_o < 20) begin
            @(negedge clk);
            lat_o++;
            if (busy) busy_o++;
            if (out_valid) begin
                res_o = out_s;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        clear_voices();
        do_reset(3);
        @(negedge clk);
        check("rst_out", 32'(out_s), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Single square voice at half volume: 32767*128>>8 = 16383
        set_voice(0, 1'b1, 2'd0, 32'h0, 8'h80);
        run_frame(lat, busy_n, res);
        check("sq_latency", 32'(lat), 32'd9);
        check("sq_busy_cycles", 32'(busy_n), 32'd8);
        check("sq_out", 32'(res), 32'h3FFF);
        @(negedge clk);
        check("sq_valid_width", 32'(out_valid), 32'h0);

        // All eight squares full volume: positive then negative saturation
        do_reset(1);
        for (int i = 0; i < 8; i++) set_voice(i, 1'b1, 2'd0, 32'h8000_0000, 8'hFF);
        run_frame(lat, busy_n, res);
        check("sat_pos", 32'(res), 32'h7FFF);
        run_frame(lat, busy_n, res);
        check("sat_neg", 32'(res), 32'h8000);

        // Saw on voice 0: -32640, -16320, 0
        do_reset(1);
        clear_voices();
        set_voice(0, 1'b1, 2'd1, 32'h4000_0000, 8'hFF);
        run_frame(lat, busy_n, res);
        check("saw_f1", 32'(res), 32'h8080);
        run_frame(lat, busy_n, res);
        check("saw_f2", 32'(res), 32'hC040);
        run_frame(lat, busy_n, res);
        check("saw_f3", 32'(res), 32'h0000);

        // Gate off silences and zeroes phase; re-gate restarts at phase 0
        gate[0] = 1'b0;
        run_frame(lat, busy_n, res);
        check("gate_off_out", 32'(res), 32'h0000);
        gate[0] = 1'b1;
        run_frame(lat, busy_n, res);
        check("gate_restart", 32'(res), 32'h8080);

        // Triangle on voice 0: -32640, 0, 32638
        do_reset(1);
        clear_voices();
        set_voice(0, 1'b1, 2'd2, 32'h4000_0000, 8'hFF);
        run_frame(lat, busy_n, res);
        check("tri_f1", 32'(res), 32'h8080);
        run_frame(lat, busy_n, res);
        check("tri_f2", 32'(res), 32'h0000);
        run_frame(lat, busy_n, res);
        check("tri_f3", 32'(res), 32'h7F7E);

        // Mode 3: silence, or LFSR noise 0xACE1 then 0xE270 scaled by 255/256
        do_reset(1);
        clear_voices();
        set_voice(0, 1'b1, 2'd3, 32'h0, 8'hFF);
        run_frame(lat, busy_n, res);
`ifdef POLY_SYNTH_NOISE_EN
        check("noise_f1", 32'(res), 32'hAD34);
`else
        check("mode3_f1", 32'(res), 32'h0000);
`endif
        run_frame(lat, busy_n, res);
`ifdef POLY_SYNTH_NOISE_EN
        check("noise_f2", 32'(res), 32'hE28D);
`else
        check("mode3_f2", 32'(res), 32'h0000);
`endif

        // Second tick mid-frame: overrun set, first result intact, one pulse only
        do_reset(1);
        clear_voices();
        set_voice(0, 1'b1, 2'd0, 32'h0, 8'h80);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        pulses = 0;
        res = '0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) res = out_s;
            end
        end
        check("ovr_pulses", 32'(pulses), 32'd1);
        check("ovr_out", 32'(res), 32'h3FFF);
        check("ovr_flag", 32'(overrun), 32'h1);

        // Reset mid-ACCUM aborts the frame and clears phases and overrun
        clear_voices();
        set_voice(0, 1'b1, 2'd1, 32'h4000_0000, 8'hFF);
        run_frame(lat, busy_n, res);
        check("abort_pre", 32'(res), 32'h8080);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_overrun", 32'(overrun), 32'h0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        run_frame(lat, busy_n, res);
        check("abort_phase_clr", 32'(res), 32'h8080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
